// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Direct-mapped branch predictor and target buffer for the fetch stage. Each entry holds a
//   valid bit, tag, saturating direction counter and predicted target. Lookup is
//   combinational; resolve-stage updates are written at the next rising edge. After reset a
//   sweep state machine clears one entry per cycle before the table is reported ready.
//
//   Optional feature: define GSHARE_EN to build a global history register that is XORed
//   into the lookup index (gshare). Without it the lookup index is taken from PC bits only.
//
// Ports
//   Clk           clock, rising edge
//   Reset         synchronous, active-high reset
//   i_lookup_pc   fetch PC (word address)
//   o_ready       table sweep finished, lookups valid
//   o_hit         valid entry with matching tag
//   o_taken       predicted direction (counter MSB), gated by o_hit
//   o_target      predicted target, 0 on miss
//   o_lookup_idx  index used for this lookup, carried down the pipe to the update
//   i_upd_valid   resolved branch update strobe
//   i_upd_idx     lookup index captured at fetch of the resolving branch
//   i_upd_pc      branch PC, supplies the tag
//   i_upd_taken   resolved direction
//   i_upd_target  resolved target
module branch_target_predictor #(
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned PC_W   = 30,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned HIST_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [PC_W-1:0]  i_lookup_pc,
    output logic             o_ready,
    output logic             o_hit,
    output logic             o_taken,
    output logic [PC_W-1:0]  o_target,
    output logic [IDX_W-1:0] o_lookup_idx,
    input  logic             i_upd_valid,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic [PC_W-1:0]  i_upd_pc,
    input  logic             i_upd_taken,
    input  logic [PC_W-1:0]  i_upd_target
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = PC_W - IDX_W;

    localparam logic [CTR_W-1:0] CtrMax = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CtrWt  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CtrWnt = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CtrOne = {{(CTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];

    logic             ready;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_accept;
    logic             upd_hit;
    logic             upd_we;
    logic             upd_valid_d;
    logic [TAG_W-1:0] upd_tag_d;
    logic [CTR_W-1:0] upd_ctr_d;
    logic [PC_W-1:0]  upd_tgt_d;

    // Low PC bits of the update are implied by i_upd_idx and carry no tag information.
    logic unused_upd_pc_lo;
    assign unused_upd_pc_lo = ^i_upd_pc[IDX_W-1:0];

    // Sweep FSM
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            StInit: begin
                sweep_d = sweep_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = StReady;
                end
            end
            StReady: ;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StInit;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign ready      = (state_q == StReady);
    assign upd_accept = ready & i_upd_valid;

`ifdef GSHARE_EN
    logic [HIST_W-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_accept) begin
            ghr_d = {ghr_q[HIST_W-2:0], i_upd_taken};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign lk_idx = i_lookup_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);
`else
    assign lk_idx = i_lookup_pc[IDX_W-1:0];
`endif

    // Lookup; gated by ready so stale or uninitialised entries never leak out during the sweep.
    assign lk_tag       = i_lookup_pc[PC_W-1:IDX_W];
    assign o_lookup_idx = lk_idx;
    assign o_ready      = ready;
    assign o_hit        = ready & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    assign o_taken      = o_hit & ctr_q[lk_idx][CTR_W-1];
    assign o_target     = o_hit ? tgt_q[lk_idx] : '0;

    // Update next-state for the addressed entry
    assign upd_tag = i_upd_pc[PC_W-1:IDX_W];
    assign upd_hit = valid_q[i_upd_idx] & (tag_q[i_upd_idx] == upd_tag);

    always_comb begin
        upd_we      = 1'b0;
        upd_valid_d = valid_q[i_upd_idx];
        upd_tag_d   = tag_q[i_upd_idx];
        upd_ctr_d   = ctr_q[i_upd_idx];
        upd_tgt_d   = tgt_q[i_upd_idx];
        if (upd_accept) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (i_upd_taken) begin
                    if (ctr_q[i_upd_idx] != CtrMax) upd_ctr_d = ctr_q[i_upd_idx] + CtrOne;
                    upd_tgt_d = i_upd_target;
                end else if (ctr_q[i_upd_idx] != '0) begin
                    upd_ctr_d = ctr_q[i_upd_idx] - CtrOne;
                end
            end else if (i_upd_taken) begin
                // Allocate only on taken; a not-taken miss leaves the entry alone.
                upd_we      = 1'b1;
                upd_valid_d = 1'b1;
                upd_tag_d   = upd_tag;
                upd_ctr_d   = CtrWt;
                upd_tgt_d   = i_upd_target;
            end
        end
    end

    // Table storage: no reset, the sweep clears it entry by entry.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state_q == StInit) begin
                valid_q[sweep_q] <= 1'b0;
                ctr_q[sweep_q]   <= CtrWnt;
            end else if (upd_we) begin
                valid_q[i_upd_idx] <= upd_valid_d;
                tag_q[i_upd_idx]   <= upd_tag_d;
                ctr_q[i_upd_idx]   <= upd_ctr_d;
                tgt_q[i_upd_idx]   <= upd_tgt_d;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: a behavioural table model is compared with
// the DUT outputs on every falling edge, plus literal checks of the directed scenarios.
module tb_branch_target_predictor;

    localparam int IDX_W   = 5;
    localparam int PC_W    = 30;
    localparam int CTR_W   = 2;
    localparam int HIST_W  = 5;
    localparam int ENTRIES = 32;
    localparam int CMAX    = (1 << CTR_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [PC_W-1:0]  i_lookup_pc;
    logic             o_ready;
    logic             o_hit;
    logic             o_taken;
    logic [PC_W-1:0]  o_target;
    logic [IDX_W-1:0] o_lookup_idx;
    logic             i_upd_valid;
    logic [IDX_W-1:0] i_upd_idx;
    logic [PC_W-1:0]  i_upd_pc;
    logic             i_upd_taken;
    logic [PC_W-1:0]  i_upd_target;

    always #5 Clk = ~Clk;

    branch_target_predictor #(
        .IDX_W (IDX_W),
        .PC_W  (PC_W),
        .CTR_W (CTR_W),
        .HIST_W(HIST_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_lookup_pc (i_lookup_pc),
        .o_ready     (o_ready),
        .o_hit       (o_hit),
        .o_taken     (o_taken),
        .o_target    (o_target),
        .o_lookup_idx(o_lookup_idx),
        .i_upd_valid (i_upd_valid),
        .i_upd_idx   (i_upd_idx),
        .i_upd_pc    (i_upd_pc),
        .i_upd_taken (i_upd_taken),
        .i_upd_target(i_upd_target)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a table of entries plus "cycles since reset" to know readiness.
    bit          m_valid[ENTRIES];
    int unsigned m_tag[ENTRIES];
    int          m_ctr[ENTRIES];
    int unsigned m_tgt[ENTRIES];
    int          m_cnt   = 0;
    bit          m_ready = 1'b0;
    int unsigned m_ghr   = 0;
    bit          chk_en  = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_cnt   <= 0;
            m_ready <= 1'b0;
            m_ghr   <= 0;
        end else if (!m_ready) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == ENTRIES - 1) begin
                m_ready <= 1'b1;
                for (int i = 0; i < ENTRIES; i++) begin
                    m_valid[i] <= 1'b0;
                    m_ctr[i]   <= (1 << (CTR_W - 1)) - 1;
                end
            end
        end else if (i_upd_valid) begin
            if (m_valid[i_upd_idx] && m_tag[i_upd_idx] == (i_upd_pc >> IDX_W)) begin
                if (i_upd_taken) begin
                    m_ctr[i_upd_idx] <= (m_ctr[i_upd_idx] >= CMAX) ? CMAX : m_ctr[i_upd_idx] + 1;
                    m_tgt[i_upd_idx] <= i_upd_target;
                end else begin
                    m_ctr[i_upd_idx] <= (m_ctr[i_upd_idx] <= 0) ? 0 : m_ctr[i_upd_idx] - 1;
                end
            end else if (i_upd_taken) begin
                m_valid[i_upd_idx] <= 1'b1;
                m_tag[i_upd_idx]   <= i_upd_pc >> IDX_W;
                m_ctr[i_upd_idx]   <= 1 << (CTR_W - 1);
                m_tgt[i_upd_idx]   <= i_upd_target;
            end
            m_ghr <= ((m_ghr << 1) | i_upd_taken) % (1 << HIST_W);
        end
    end

    task automatic compare_outputs();
        int unsigned idx;
        int unsigned tag;
        bit          hit;
        idx = i_lookup_pc % ENTRIES;
`ifdef GSHARE_EN
        idx = idx ^ m_ghr;
`endif
        tag = i_lookup_pc >> IDX_W;
        hit = m_ready && m_valid[idx] && (m_tag[idx] == tag);
        check("ready", o_ready, m_ready);
        check("lookup_idx", o_lookup_idx, idx);
        check("hit", o_hit, hit);
        check("taken", o_taken, hit && (m_ctr[idx] >= (1 << (CTR_W - 1))));
        check("target", o_target, hit ? m_tgt[idx] : 0);
    endtask

    always @(negedge Clk) if (chk_en) compare_outputs();

    task automatic set_in(input int unsigned pc, input bit uv, input int unsigned uidx,
                          input int unsigned upc, input bit ut, input int unsigned utgt);
        i_lookup_pc  = pc[PC_W-1:0];
        i_upd_valid  = uv;
        i_upd_idx    = uidx[IDX_W-1:0];
        i_upd_pc     = upc[PC_W-1:0];
        i_upd_taken  = ut;
        i_upd_target = utgt[PC_W-1:0];
    endtask

    // Advance one edge and land just after the following falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    function automatic int unsigned pool_pc();
        return ((($urandom % 4) << IDX_W) | ($urandom % 8));
    endfunction

    // Reset edge already pending; checks o_ready over the sweep, optionally with update noise.
    task automatic sweep_check(input bit noisy);
        @(posedge Clk);
        for (int k = 1; k <= 33; k++) begin
            @(negedge Clk);
            #1;
            check("ready_sweep", o_ready, (k == 33));
            if (k == 1) Reset = 1'b0;
            if (noisy && k < 33) set_in(pool_pc(), 1'b1, $urandom % 8, pool_pc(), 1'b1, $urandom);
            else set_in($urandom, 1'b0, 0, 0, 1'b0, 0);
        end
    endtask

    initial begin
        int unsigned upc;
        Reset = 1'b1;
        set_in(0, 1'b0, 0, 0, 1'b0, 0);
        @(posedge Clk);
        @(negedge Clk);
        chk_en = 1'b1;
        #1;
        sweep_check(1'b0);

        // Allocate pc 0x40; the same-cycle lookup still sees the old miss.
        set_in(32'h40, 1'b1, 0, 32'h40, 1'b1, 32'h100);
        #1;
        check("alloc_same_cycle_hit", o_hit, 1'b0);
        tick();
        set_in(32'h40, 1'b0, 0, 0, 1'b0, 0);
        #1;
        check("alloc_hit", o_hit, 1'b1);
        check("alloc_taken", o_taken, 1'b1);
        check("alloc_target", o_target, 32'h100);
        set_in(32'h60, 1'b0, 0, 0, 1'b0, 0);
        #1;
        check("other_tag_hit", o_hit, 1'b0);

        // Saturation: 2 -> 3 (x3 taken) -> 2 -> 1 -> 0 -> 0
        repeat (3) begin
            set_in(32'h40, 1'b1, 0, 32'h40, 1'b1, 32'h100);
            tick();
        end
        set_in(32'h40, 1'b1, 0, 32'h40, 1'b0, 0);
        tick();
        set_in(32'h40, 1'b0, 0, 0, 1'b0, 0);
        #1;
        check("sat_hit", o_hit, 1'b1);
        check("sat_taken_ctr2", o_taken, 1'b1);
        repeat (3) begin
            set_in(32'h40, 1'b1, 0, 32'h40, 1'b0, 0);
            tick();
        end
        set_in(32'h40, 1'b0, 0, 0, 1'b0, 0);
        #1;
        check("floor_hit", o_hit, 1'b1);
        check("floor_taken_ctr0", o_taken, 1'b0);
        check("floor_target", o_target, 32'h100);

        // Miss, not-taken does not allocate
        set_in(32'h7, 1'b1, 7, 32'h7, 1'b0, 32'h55);
        tick();
        set_in(32'h7, 1'b0, 0, 0, 1'b0, 0);
        #1;
        check("miss_nt_no_alloc", o_hit, 1'b0);

        // Random traffic over a small PC pool so entries collide and saturate
        for (int n = 0; n < 3000; n++) begin
            upc = pool_pc();
            set_in(($urandom % 8 == 0) ? $urandom : pool_pc(), ($urandom % 2 == 0),
                   ($urandom % 16 == 0) ? ($urandom % ENTRIES) : (upc % ENTRIES),
                   upc, ($urandom % 5 < 3), $urandom);
            tick();
        end

        // Reset at sweep cycle 10 restarts a full sweep; updates during the sweep are ignored.
        set_in(0, 1'b0, 0, 0, 1'b0, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int k = 1; k < 10; k++) begin
            set_in(32'h40, 1'b1, 0, 32'h40, 1'b1, 32'h100);
            tick();
            check("ready_mid_sweep", o_ready, 1'b0);
        end
        Reset = 1'b1;
        sweep_check(1'b1);
        set_in(32'h40, 1'b0, 0, 0, 1'b0, 0);
        #1;
        check("sweep_no_alloc_40", o_hit, 1'b0);
        for (int p = 0; p < 8; p++) begin
            set_in((p << IDX_W) | p, 1'b0, 0, 0, 1'b0, 0);
            #1;
            check("sweep_cleared", o_hit, 1'b0);
        end

        // History: taken, taken, not-taken -> 5'b00110; pc 0x3 then indexes 5'b00101.
        set_in(0, 1'b1, 0, 32'h200, 1'b1, 32'h10);
        tick();
        set_in(0, 1'b1, 0, 32'h200, 1'b1, 32'h10);
        tick();
        set_in(0, 1'b1, 0, 32'h200, 1'b0, 0);
        tick();
        set_in(32'h3, 1'b0, 0, 0, 1'b0, 0);
        #1;
`ifdef GSHARE_EN
        check("gshare_idx", o_lookup_idx, 5'b00101);
`else
        check("pc_idx", o_lookup_idx, 5'b00011);
`endif
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
